alu_accum_core: RTL and testbench

ALU_ACCUM_CORE -- requirements
Module: alu_accum_core

---
 rtl/alu_accum_core_pkg.sv | 23 ++
 rtl/alu_accum_core_adder_subber.sv | 23 ++
 rtl/alu_accum_core.sv | 89 ++++++++
 tb/tb_alu_accum_core.sv | 113 +++++++++++
 4 files changed

// File: rtl/alu_accum_core_pkg.sv
// Shared constants and types for the accumulator ALU: opcode encodings,
// default datapath width and the registered flag bundle.
package alu_accum_core_pkg;

  localparam int WIDTH_DEFAULT = 16;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b1000;
  localparam logic [3:0] OP_SUB   = 4'b1001;
  localparam logic [3:0] OP_CLEAR = 4'b1111;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic error;
  } alu_flags_t;

  // ADD and SUB are the only opcodes that route through the adder and raise flags.
  function automatic logic is_arith(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_accum_core_adder_subber.sv
// Shared WIDTH-bit adder/subtractor: subtraction is x + ~y + 1, so carry=1 means no borrow.
module adder_subber #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  logic [WIDTH-1:0] y_eff_s;
  logic [WIDTH:0]   full_s;

  assign y_eff_s = sub ? ~y : y;
  assign full_s  = {1'b0, x} + {1'b0, y_eff_s} + {{WIDTH{1'b0}}, sub};
  assign sum     = full_s[WIDTH-1:0];
  assign carry   = full_s[WIDTH];
  // Signed overflow: like-signed effective operands producing a differently signed sum.
  assign overflow = (x[WIDTH-1] == y_eff_s[WIDTH-1]) && (full_s[WIDTH-1] != x[WIDTH-1]);

endmodule

// File: rtl/alu_accum_core.sv
// Two-stage accumulator ALU: stage 1 captures operands/opcode, stage 2 registers
// the selected operation's value and flags. Unknown opcodes behave as CLEAR.
module alu_accum_core
  import alu_accum_core_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             error
);

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [3:0]       op_code;

  logic [WIDTH-1:0] sum_s;
  logic             sum_carry_s;
  logic             sum_overflow_s;
  logic [WIDTH-1:0] value_s;
  alu_flags_t       flags_s;

  // Stage 1: operand/opcode capture; reset parks the opcode on CLEAR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a    <= {WIDTH{1'b0}};
      op_b    <= {WIDTH{1'b0}};
      op_code <= OP_CLEAR;
    end else begin
      op_a    <= a;
      op_b    <= b;
      op_code <= opcode;
    end
  end

  adder_subber #(.WIDTH(WIDTH)) u_adder_subber (
    .x        (op_a),
    .y        (op_b),
    .sub      (op_code == OP_SUB),
    .sum      (sum_s),
    .carry    (sum_carry_s),
    .overflow (sum_overflow_s)
  );

  // Operation select: value and flags for the captured opcode.
  always_comb begin
    value_s = {WIDTH{1'b0}};
    flags_s = '{carry: 1'b0, overflow: 1'b0, error: 1'b0};
    case (op_code)
      OP_AND: begin
        value_s = op_a & op_b;
      end
      OP_ADD, OP_SUB: begin
        value_s          = sum_s;
        flags_s.carry    = sum_carry_s;
        flags_s.overflow = sum_overflow_s;
        flags_s.error    = sum_overflow_s && is_arith(op_code);
      end
      OP_CLEAR: begin
        value_s = {WIDTH{1'b0}};
      end
      default: begin
        value_s = {WIDTH{1'b0}};
      end
    endcase
  end

  // Stage 2: accumulator and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result   <= {WIDTH{1'b0}};
      carry    <= 1'b0;
      overflow <= 1'b0;
      error    <= 1'b0;
    end else begin
      result   <= value_s;
      carry    <= flags_s.carry;
      overflow <= flags_s.overflow;
      error    <= flags_s.error;
    end
  end

endmodule

// File: tb/tb_alu_accum_core.sv
// Directed bench for alu_accum_core: hand-computed vectors, pipeline streaming and async reset.
module tb_alu_accum_core;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   opcode;
  logic [W-1:0] result;
  logic         carry;
  logic         overflow;
  logic         error;

  int checks;
  int failures;

  alu_accum_core #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .opcode   (opcode),
    .result   (result),
    .carry    (carry),
    .overflow (overflow),
    .error    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] exp_res,
                       input logic exp_c, input logic exp_v, input logic exp_e);
    logic [W+2:0] got;
    logic [W+2:0] exp;
    got = {result, carry, overflow, error};
    exp = {exp_res, exp_c, exp_v, exp_e};
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got result=%h c=%b v=%b e=%b, expected result=%h c=%b v=%b e=%b",
             tag, result, carry, overflow, error, exp_res, exp_c, exp_v, exp_e);
    end
  endtask

  // Drive one op, let it pass both stages, then sample 1 time unit after the second edge.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [3:0] top);
    a = ta;
    b = tb;
    opcode = top;
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst    = 1'b1;
    a      = 16'h0000;
    b      = 16'h0000;
    opcode = 4'b1000;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 16'h0000, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    do_op(16'h250A, 16'h3C3C, 4'b0000); check("and",          16'h2408, 1'b0, 1'b0, 1'b0);
    do_op(16'h001E, 16'h0007, 4'b1000); check("add_30_7",     16'h0025, 1'b0, 1'b0, 1'b0);
    do_op(16'h001E, 16'h0007, 4'b1111); check("clear",        16'h0000, 1'b0, 1'b0, 1'b0);
    do_op(16'hBC40, 16'h9C40, 4'b1000); check("add_ovf",      16'h5880, 1'b1, 1'b1, 1'b1);
    do_op(16'hBC40, 16'h9C40, 4'b1010); check("unlisted_1010",16'h0000, 1'b0, 1'b0, 1'b0);
    do_op(16'h0007, 16'h001E, 4'b1001); check("sub_7_30",     16'hFFE9, 1'b0, 1'b0, 1'b0);
    do_op(16'h001E, 16'h0007, 4'b1001); check("sub_30_7",     16'h0017, 1'b1, 1'b0, 1'b0);
    do_op(16'hFFFF, 16'h0001, 4'b1000); check("add_wrap",     16'h0000, 1'b1, 1'b0, 1'b0);
    do_op(16'h8000, 16'h0001, 4'b1001); check("sub_ovf",      16'h7FFF, 1'b1, 1'b1, 1'b1);
    do_op(16'h7FFF, 16'h0001, 4'b1000); check("add_pos_ovf",  16'h8000, 1'b0, 1'b1, 1'b1);
    do_op(16'hFFFF, 16'hFFFF, 4'b0001); check("unlisted_0001",16'h0000, 1'b0, 1'b0, 1'b0);
    do_op(16'h1234, 16'h1234, 4'b1001); check("sub_equal",    16'h0000, 1'b1, 1'b0, 1'b0);

    // Back-to-back issue: one new op per cycle, each visible one cycle after the previous.
    a = 16'hF0F0; b = 16'hFF00; opcode = 4'b0000;
    @(posedge clk); #1;
    a = 16'h0100; b = 16'h0023; opcode = 4'b1000;
    @(posedge clk); #1;
    check("stream_and", 16'hF000, 1'b0, 1'b0, 1'b0);
    a = 16'h0005; b = 16'h0003; opcode = 4'b1001;
    @(posedge clk); #1;
    check("stream_add", 16'h0123, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("stream_sub", 16'h0002, 1'b1, 1'b0, 1'b0);

    // Async reset right after an ADD is captured, before it reaches stage 2.
    do_op(16'hBC40, 16'h9C40, 4'b1000); check("pre_reset",    16'h5880, 1'b1, 1'b1, 1'b1);
    a = 16'h0001; b = 16'h0001; opcode = 4'b1000;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_reset_first_edge", 16'h0000, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("post_reset_second_edge", 16'h0002, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
